// File: rtl/apb_pkg.sv
// APB state encodings and default bus widths, shared by
// the arbitrated master and the RAM slave.
package apb_pkg;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ADDR_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'b01,
    SETUP  = 2'b10,
    ACCESS = 2'b11
  } apb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: priority starts one above
// last_grant and wraps; masked requesters are skipped.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  input  logic [NUM_REQ-1:0]         mask,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] avail;
  int                 k;

  assign avail = req & ~mask;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    k         = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = (int'(last_grant) + i) % NUM_REQ;
      if (avail[k]) begin
        grant     = '0;
        grant[k]  = 1'b1;
        grant_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port among NUM_REQ requesters.
// Optional ACCESS timeout abort: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int data_size    = DEF_DATA_SIZE,
  parameter int address_size = DEF_ADDR_SIZE,
  parameter int TIMEOUT      = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*address_size-1:0] req_addr,
  input  logic [NUM_REQ*data_size-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]              req_done,
  output logic                            req_err,
  output logic [data_size-1:0]            req_rdata,
  output logic                            pselx,
  output logic                            penable,
  output logic                            pwrite,
  output logic [address_size-1:0]         paddr,
  output logic [data_size-1:0]            pwdata,
  input  logic                            pready,
  input  logic [data_size-1:0]            prdata
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("apb_master_arbiter: unsupported parameters");
  end

  apb_state_t         state, state_nx;
  logic [IW-1:0]      last_grant, owner, grant_idx, arb_last;
  logic [NUM_REQ-1:0] grant, mask, owner_oh;
  logic               win, done, tmo, load;

  assign owner_oh = NUM_REQ'(1) << owner;
  assign done     = (state == ACCESS) && (pready || tmo);
  // The finishing owner is masked and priority restarts just above it.
  assign mask     = done ? owner_oh : '0;
  assign arb_last = done ? owner : last_grant;
  assign win      = |grant;
  assign load     = win && ((state == IDLE) || done);

  assign pselx   = (state != IDLE);
  assign penable = (state == ACCESS);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (arb_last),
    .mask       (mask),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset || state == SETUP)
      wait_cnt <= '0;
    else if (state == ACCESS && !pready)
      wait_cnt <= wait_cnt + CW'(1);
  end

  assign tmo = (state == ACCESS) && !pready &&
               (wait_cnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (win) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (done) state_nx = win ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      owner      <= '0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      req_done   <= '0;
      req_err    <= 1'b0;
      req_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        owner  <= grant_idx;
        pwrite <= req_write[grant_idx];
        paddr  <= req_addr[grant_idx*address_size +: address_size];
        pwdata <= req_wdata[grant_idx*data_size +: data_size];
      end
      if (done) last_grant <= owner;
      req_done  <= done ? owner_oh : '0;
      req_err   <= tmo;
      req_rdata <= (done && !pwrite && !tmo) ? prdata : '0;
    end
  end

endmodule
